// File: rtl/sub_bytes_pkg.sv
// Shared types, AES S-box tables and byte lookup helper
// for the folded SubBytes engine.
package sub_bytes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(
    input logic [7:0] value,
    input logic       inv
  );
    return inv ? INV_SBOX[value] : SBOX[value];
  endfunction

endpackage

// File: rtl/sub_bytes_folded_if.sv
// Block in/out handshake bundle for the folded SubBytes engine.
// master drives blocks in and takes results; slave is the engine.
interface sub_bytes_folded_if #(
  parameter int DATA_WIDTH = 512
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic                  inv;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output in_valid,
    output inv,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  inv,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out
  );

endinterface

// File: rtl/sbox_dual.sv
// Single-byte forward/inverse AES S-box lane.
// Purely combinational table lookup.
module sbox_dual
  import sub_bytes_pkg::*;
(
  input  logic [7:0] value,
  input  logic       inv,
  output logic [7:0] result
);

  assign result = sbox_lookup(value, inv);

endmodule

// File: rtl/sub_bytes_folded.sv
// Folded SubBytes: LANES S-box lanes sweep the block in place,
// NSTEPS cycles per block, results held until handshake.
module sub_bytes_folded
  import sub_bytes_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int LANES      = 8
) (
  input  logic         clk,
  input  logic         reset,
  sub_bytes_folded_if.slave bus,
  output logic         busy
);

  localparam int NO_BYTES = DATA_WIDTH / 8;
  localparam int NSTEPS   = NO_BYTES / LANES;
  localparam int CW       = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int SW       = LANES * 8;
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  state_t                    state;
  state_t                    state_n;
  logic [CW-1:0]             cnt;
  logic                      mode;
  logic [NSTEPS-1:0][SW-1:0] work;
  logic [SW-1:0]             lane_in;
  logic [SW-1:0]             lane_out;
  logic                      load;
  logic                      in_ready;
  logic                      out_valid;

  // the work register viewed as NSTEPS slices; cnt picks the slice
  assign lane_in = work[cnt];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_dual u_sbox (
      .value  (lane_in[l*8 +: 8]),
      .inv    (mode),
      .result (lane_out[l*8 +: 8])
    );
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          in_ready = 1'b1;
          if (bus.in_valid) begin
            load    = 1'b1;
            state_n = BUSY;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      work  <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        work <= bus.data_in;
        mode <= bus.inv;
        cnt  <= '0;
      end else if (state == BUSY) begin
        work[cnt] <= lane_out;
        cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.data_out  = work;
  assign busy          = (state == BUSY);

endmodule

// File: doc/sub_bytes_folded.md
SUB_BYTES_FOLDED -- requirements
Module: sub_bytes_folded

Interface
REQ-001 Parameter DATA_WIDTH, default 512: block width in bits; SHALL be a multiple of 8.
REQ-002 Parameter LANES, default 8: bytes substituted per cycle; SHALL divide DATA_WIDTH/8 exactly.
REQ-003 Port clk  input  1  system clock; all state SHALL change on its rising edge, except on reset.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  data_in and inv are valid this cycle.
REQ-006 Port in_ready  output  1  block accepts input this cycle.
REQ-007 Port inv  input  1  mode: 0 = forward AES S-box, 1 = inverse S-box; sampled with data_in.
REQ-008 Port data_in  input  DATA_WIDTH  input block; byte i is bits [8i+7:8i].
REQ-009 Port out_valid  output  1  data_out holds a complete result.
REQ-010 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port data_out  output  DATA_WIDTH  substituted block, same byte order as data_in.
REQ-012 Port busy  output  1  high in state BUSY.

Function
REQ-013 Derived constants: NO_BYTES = DATA_WIDTH/8; NSTEPS = NO_BYTES/LANES; the step counter SHALL be max(1, clog2(NSTEPS)) bits wide.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1; in_valid=1 latches data_in into the work register, latches inv into a mode register, clears the counter and enters BUSY.
REQ-016 BUSY: in step k (0..NSTEPS-1), bytes k*LANES .. k*LANES+LANES-1 of the work register SHALL be replaced in place by their S-box values under the latched mode; the counter SHALL increment each cycle.
REQ-017 BUSY at step NSTEPS-1 SHALL transition to DONE on the same edge that writes the final lanes.
REQ-018 DONE: out_valid=1, and data_out SHALL equal the work register, stable until the handshake completes.
REQ-019 DONE with out_ready=0: the block SHALL hold all state.
REQ-020 DONE with out_ready=1 and in_valid=0: go to IDLE.
REQ-021 DONE with out_ready=1 and in_valid=1: load the new block and go directly to BUSY (back-to-back); in_ready SHALL therefore equal (IDLE) or (DONE and out_ready).
REQ-022 Latency: from the accept edge, out_valid SHALL rise exactly NSTEPS cycles later; sustained throughput SHALL be one block per NSTEPS+1 cycles.
REQ-023 LANES = NO_BYTES (NSTEPS=1): BUSY SHALL last exactly one cycle.
REQ-024 Changes to inv or data_in while not accepting SHALL have no effect on an in-flight block.
REQ-025 in_ready and out_valid SHALL be combinational functions of state and out_ready only, never of in_valid.
REQ-026 Untouched bytes of the work register SHALL keep their input values until their step.

Reset
REQ-027 On reset=1, asynchronously: state=IDLE, counter=0, mode register=0, work register=0, out_valid=0, busy=0.
REQ-028 Reset asserted in BUSY or DONE SHALL discard the block; no out_valid SHALL appear for it after release.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-030 Package sub_bytes_pkg SHALL hold: the state enum; the 256-entry forward and inverse S-box constant tables; and a function returning the forward or inverse S-box value for a byte, selected by mode.
REQ-031 One sub-module, sbox_dual: purely combinational, ports byte in, inv, byte out; instantiated LANES times in a generate loop.
REQ-032 The lane input mux SHALL select the bytes for the current step by counter; no per-lane registers outside the work register.

Verification
REQ-033 Forward mode, DATA_WIDTH=512, LANES=8, all bytes 0x00, inv=0 -> out_valid 8 cycles after accept; every byte of data_out = 0x63.
REQ-034 Inverse mode, all bytes 0x63, inv=1 -> every byte = 0x00; byte 0 = 0xED with inv=1 -> byte 0 of data_out = 0x53.
REQ-035 Mixed block: byte i = i, inv=0 -> byte 0 = 0x63, byte 1 = 0x7C, byte 0x53 (DATA_WIDTH>=672 build) = 0xED; random blocks compared against the package function.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> data_out stable and in_ready=0; then out_ready=1 with in_valid=1 -> new block accepted on the same edge, next out_valid NSTEPS cycles later.
REQ-037 Reset pulse at step 3 of BUSY -> next cycle state=IDLE, out_valid=0, in_ready=1 after release; the aborted block is never output.
REQ-038 Parameter sweep: LANES=64 (1 step), LANES=1 (64 steps), DATA_WIDTH=128 with LANES=4 -> correct results and latency = NSTEPS.
